myproject_mac_pipe: RTL and testbench
=====================================

// Module: myproject_mac_pipe
// PURPOSE
//  Pipelined signed multiply-accumulate for dense-layer dot products. Generalises the single-cycle signed
//  multiplier: parametrised widths and latency, accumulation across a term stream framed by in_last,
//  and output requantisation with selectable rounding and saturation. Sits between weight/activation
//  streams and the layer output buffer, with valid/ready on both sides.
// PARAMETERS
//  DIN0_WIDTH   16  signed activation width
//  DIN1_WIDTH   8   signed weight width
//  ACC_WIDTH    32  signed accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH
//  DOUT_WIDTH   16  signed result width
//  FRAC_SHIFT   6   arithmetic right shift applied at requantisation (0..ACC_WIDTH-1)
//  NUM_STAGE    2   multiplier pipeline depth, 1..4
//  RND_MODE     1   0 = truncate (floor); 1 = round half up (add 2^(FRAC_SHIFT-1), then floor)
//  SAT_MODE     1   0 = wrap to DOUT_WIDTH; 1 = clamp to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]
// PORTS
//  ap_clk     in   1           clock; all state changes on the rising edge
//  ap_rst_n   in   1           synchronous reset, active low
//  ce         in   1           global clock enable; 0 freezes every register
//  in_valid   in   1           din0/din1/in_last valid
//  in_ready   out  1           term accepted when in_valid && in_ready
//  in_last    in   1           final term of the current dot product
//  din0       in   DIN0_WIDTH  signed activation
//  din1       in   DIN1_WIDTH  signed weight
//  out_valid  out  1           dout/ovf valid
//  out_ready  in   1           downstream accepts when out_valid && out_ready
//  dout       out  DOUT_WIDTH  requantised dot product
//  ovf        out  1           result did not fit DOUT_WIDTH (clamped or wrapped)
// BEHAVIOUR
//  - Reset (ap_rst_n=0 at an edge): out_valid=0, dout=0, ovf=0, accumulator=0, all stage valids=0.
//    Reset wins over ce and clears in-flight terms and any partial sum mid-stream.
//  - in_ready = ce && adv. Pipeline advance: adv = !(out_valid && !out_ready). When adv=0, every stage holds.
//  - Product: p = signed(din0)*signed(din1), full width DIN0_WIDTH+DIN1_WIDTH, sign-extended to ACC_WIDTH.
//    Carried through NUM_STAGE registers with its valid and last bits.
//  - Accumulate stage, on a valid product with adv && ce:
//    - sum = acc + p; ACC_WIDTH two's-complement wrap with no flag.
//    - last=0: acc <= sum.
//    - last=1: sum goes to requantiser, acc <= 0, so the next term starts a fresh dot product with no bubble.
//  - Requantise, combinational into the output register:
//    - r = (sum + (RND_MODE ? 2^(FRAC_SHIFT-1) : 0)) >>> FRAC_SHIFT. The rounding add is skipped when FRAC_SHIFT=0.
//    - SAT_MODE=1: out-of-range r is clamped and ovf=1.
//    - SAT_MODE=0: dout = r[DOUT_WIDTH-1:0] and ovf=1 when truncation changed the value.
//  - Output register: loads dout/ovf and sets out_valid on a last result. Holds dout/ovf stable while
//    out_valid && !out_ready. Clears out_valid on handshake unless a new result loads the same cycle,
//    which allows back-to-back results.
//  - Latency: term with in_last accepted at edge t -> out_valid=1 after edge t+NUM_STAGE+1 (no stalls).
//    Throughput is 1 term/cycle.
//  - Single-term dot products (in_last on every term) yield one result per cycle.
//  - in_valid=0 inserts bubbles; accumulator is untouched by bubbles.
//  - ce=0: all registers hold and in_ready=0. out_valid/dout stay visible, but the output register does
//    not clear, so a handshake is not consumed.
// TESTING
//  1 Single term din0=100, din1=3, last=1, defaults -> dout=5, ovf=0, NUM_STAGE+1 cycles after accept; RND_MODE=0 -> dout=4.
//  2 Negative rounding: din0=-100, din1=3, last -> dout=-5 (RND_MODE=1), -5 (RND_MODE=0, floor of -4.6875).
//  3 Saturation: din0=-32768, din1=-128, last -> sum=4194304 -> dout=32767, ovf=1; SAT_MODE=0 -> dout=0, ovf=1.
//  4 Stream of 4 terms (10,64),(20,64),(-5,64),(7,64 last), then a new 1-term (64,64 last), back to back
//    -> dout=32 then 64, consecutive cycles, no cross-contamination.
//  5 out_ready=0 for 5 cycles with 3 results queued -> in_ready=0, first dout held stable; on release
//    all 3 delivered in order, none lost or duplicated.
//  6 ap_rst_n=0 for one cycle after 2 of 4 terms -> out_valid=0. Next 1-term dot product (64,64 last) -> 64.
//    Also toggle ce=0 mid-stream -> identical results, delayed by the stalled cycles.

Source files
------------

// File: rtl/myproject_mac_pipe.sv
// Pipelined signed multiply-accumulate with stream framing and output requantisation.
// Products travel through NUM_STAGE registers, are summed in an accumulate stage that
// restarts on every in_last, then are rounded, shifted and saturated into a registered
// valid/ready output. One global stall signal freezes the whole pipe when the output
// is blocked or ce is low.

module myproject_mac_pipe #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int DOUT_WIDTH = 16,
    parameter int FRAC_SHIFT = 6,
    parameter int NUM_STAGE  = 2,
    parameter int RND_MODE   = 1,
    parameter int SAT_MODE   = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf
);

    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
    // One guard bit above the accumulator so the rounding add can never wrap.
    localparam int EXT_WIDTH  = ACC_WIDTH + 1;
    localparam int RND_POS    = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

    localparam logic signed [EXT_WIDTH-1:0] RND_ADD =
        (RND_MODE != 0 && FRAC_SHIFT > 0) ? (EXT_WIDTH'(1) << RND_POS) : EXT_WIDTH'(0);
    localparam logic signed [EXT_WIDTH-1:0] SAT_MAX =
        {{(EXT_WIDTH - DOUT_WIDTH + 1){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
    localparam logic signed [EXT_WIDTH-1:0] SAT_MIN =
        {{(EXT_WIDTH - DOUT_WIDTH + 1){1'b1}}, {(DOUT_WIDTH - 1){1'b0}}};

    logic                         adv;
    logic                         en;

    logic signed [PROD_WIDTH-1:0] prod_full;
    logic signed [ACC_WIDTH-1:0]  prod_ext;

    logic signed [ACC_WIDTH-1:0]  prod_q [NUM_STAGE];
    logic signed [ACC_WIDTH-1:0]  prod_d [NUM_STAGE];
    logic [NUM_STAGE-1:0]         vld_q;
    logic [NUM_STAGE-1:0]         vld_d;
    logic [NUM_STAGE-1:0]         last_q;
    logic [NUM_STAGE-1:0]         last_d;

    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  res_q;
    logic signed [ACC_WIDTH-1:0]  res_d;
    logic                         res_vld_q;
    logic                         res_vld_d;

    logic signed [EXT_WIDTH-1:0]  rq_biased;
    logic signed [EXT_WIDTH-1:0]  rq_shifted;
    logic signed [DOUT_WIDTH-1:0] rq_dout;
    logic                         rq_ovf;

    logic                         out_valid_q;
    logic                         out_valid_d;
    logic signed [DOUT_WIDTH-1:0] dout_q;
    logic signed [DOUT_WIDTH-1:0] dout_d;
    logic                         ovf_q;
    logic                         ovf_d;

    // The whole pipe moves together: a blocked output or a low ce holds every stage.
    assign adv      = !(out_valid_q && !out_ready);
    assign en       = ce && adv;
    assign in_ready = en;

    // Full-precision signed product, sign-extended to the accumulator width.
    assign prod_full = PROD_WIDTH'(din0) * PROD_WIDTH'(din1);
    assign prod_ext  = ACC_WIDTH'(prod_full);

    // Shift the product, valid and last bits one stage along whenever the pipe advances.
    always_comb begin
        prod_d = prod_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (en) begin
            prod_d[0] = prod_ext;
            vld_d[0]  = in_valid;
            last_d[0] = in_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_d[i] = prod_q[i-1];
                vld_d[i]  = vld_q[i-1];
                last_d[i] = last_q[i-1];
            end
        end
    end

    // Multiplier pipeline registers; reset drops every in-flight term.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                prod_q[i] <= '0;
            end
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign sum = acc_q + prod_q[NUM_STAGE-1];

    // Accumulate terms; a last term hands its total to the requantiser and restarts at zero.
    always_comb begin
        acc_d     = acc_q;
        res_d     = res_q;
        res_vld_d = res_vld_q;
        if (en) begin
            res_vld_d = vld_q[NUM_STAGE-1] && last_q[NUM_STAGE-1];
            if (vld_q[NUM_STAGE-1]) begin
                if (last_q[NUM_STAGE-1]) begin
                    acc_d = '0;
                    res_d = sum;
                end else begin
                    acc_d = sum;
                end
            end
        end
    end

    // Accumulator and completed-sum registers; reset discards any partial dot product.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
        end
    end

    // Rounding bias then arithmetic shift, computed with a guard bit so nothing wraps.
    assign rq_biased  = EXT_WIDTH'(res_q) + RND_ADD;
    assign rq_shifted = rq_biased >>> FRAC_SHIFT;

    // Fit the shifted value into the output width, either clamping or wrapping, and flag misfits.
    always_comb begin
        rq_dout = rq_shifted[DOUT_WIDTH-1:0];
        rq_ovf  = 1'b0;
        if (SAT_MODE != 0) begin
            if (rq_shifted > SAT_MAX) begin
                rq_dout = SAT_MAX[DOUT_WIDTH-1:0];
                rq_ovf  = 1'b1;
            end else if (rq_shifted < SAT_MIN) begin
                rq_dout = SAT_MIN[DOUT_WIDTH-1:0];
                rq_ovf  = 1'b1;
            end
        end else begin
            rq_ovf = (EXT_WIDTH'(rq_dout) != rq_shifted);
        end
    end

    // Output register loads a new result or drains on handshake; it never changes while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        if (en) begin
            out_valid_d = res_vld_q;
            if (res_vld_q) begin
                dout_d = rq_dout;
                ovf_d  = rq_ovf;
            end
        end
    end

    // Registered result and flags presented downstream.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Bench for myproject_mac_pipe. Two instances share one term stream: "a" with default
// parameters (round, saturate, two stages) and "b" with truncation, wrap and a single
// stage. Instance b only sees terms that a accepts and is never back-pressured, so
// both consume identical dot products. A scoreboard computes expected results from
// plain integer arithmetic, alongside fixed vectors and hand-written corner sequences.

module tb_myproject_mac_pipe;

    localparam int ACC_W  = 32;
    localparam int DOUT_W = 16;
    localparam int FRAC   = 6;

    typedef struct {
        int d0;
        int d1;
        int exp_a;
        bit ovf_a;
        int exp_b;
        bit ovf_b;
    } vec_t;

    typedef struct {
        longint d;
        bit     o;
    } exp_t;

    logic               clk = 1'b0;
    logic               ap_rst_n;
    logic               ce;
    logic               in_valid;
    logic               in_last;
    logic signed [15:0] din0;
    logic signed [7:0]  din1;
    logic               out_ready;
    logic               in_ready_a;
    logic               out_valid_a;
    logic signed [15:0] dout_a;
    logic               ovf_a;
    logic               in_valid_b;
    logic               in_ready_b;
    logic               out_valid_b;
    logic signed [15:0] dout_b;
    logic               ovf_b;
    logic               ready_b = 1'b1;

    int     checks = 0;
    int     errors = 0;
    longint model_acc = 0;
    exp_t   qa[$];
    exp_t   qb[$];
    vec_t   vecs[$];

    always #5 clk = ~clk;

    assign in_valid_b = in_valid && in_ready_a;

    myproject_mac_pipe dut_a (
        .ap_clk   (clk),
        .ap_rst_n (ap_rst_n),
        .ce       (ce),
        .in_valid (in_valid),
        .in_ready (in_ready_a),
        .in_last  (in_last),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid_a),
        .out_ready(out_ready),
        .dout     (dout_a),
        .ovf      (ovf_a)
    );

    myproject_mac_pipe #(
        .NUM_STAGE(1),
        .RND_MODE (0),
        .SAT_MODE (0)
    ) dut_b (
        .ap_clk   (clk),
        .ap_rst_n (ap_rst_n),
        .ce       (ce),
        .in_valid (in_valid_b),
        .in_ready (in_ready_b),
        .in_last  (in_last),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid_b),
        .out_ready(ready_b),
        .dout     (dout_b),
        .ovf      (ovf_b)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Two's-complement wrap of an arbitrary integer into the accumulator width.
    function automatic longint wrapAcc(input longint v);
        longint m;
        m = v % (64'sd1 <<< ACC_W);
        if (m < 0) m += (64'sd1 <<< ACC_W);
        if (m >= (64'sd1 <<< (ACC_W - 1))) m -= (64'sd1 <<< ACC_W);
        return m;
    endfunction

    // Expected result: floor((s + bias) / 2^FRAC), then clamp or wrap into DOUT_W bits.
    function automatic exp_t requant(input longint s, input bit rnd, input bit sat);
        exp_t   e;
        longint div;
        longint n;
        longint q;
        longint lo;
        longint hi;
        longint m;
        div = 64'sd1 <<< FRAC;
        n   = s + ((rnd && FRAC > 0) ? (div / 2) : 0);
        q   = n / div;
        if ((n % div != 0) && (n < 0)) q -= 1;
        lo = -(64'sd1 <<< (DOUT_W - 1));
        hi = (64'sd1 <<< (DOUT_W - 1)) - 1;
        if (sat) begin
            e.d = (q > hi) ? hi : ((q < lo) ? lo : q);
        end else begin
            m = (q - lo) % (64'sd1 <<< DOUT_W);
            if (m < 0) m += (64'sd1 <<< DOUT_W);
            e.d = m + lo;
        end
        e.o = (e.d != q);
        return e;
    endfunction

    // Scoreboard: mirrors accepted terms and checks every output handshake in order.
    always @(negedge clk) begin
        exp_t e;
        if (!ap_rst_n) begin
            qa.delete();
            qb.delete();
            model_acc = 0;
        end else begin
            if (ce && out_valid_a && out_ready) begin
                if (qa.size() == 0) begin
                    checkOutput("sb_spurious_a", 1, 0);
                end else begin
                    e = qa.pop_front();
                    checkOutput("sb_dout_a", longint'(dout_a), e.d);
                    checkOutput("sb_ovf_a", longint'(ovf_a), longint'(e.o));
                end
            end
            if (ce && out_valid_b) begin
                if (qb.size() == 0) begin
                    checkOutput("sb_spurious_b", 1, 0);
                end else begin
                    e = qb.pop_front();
                    checkOutput("sb_dout_b", longint'(dout_b), e.d);
                    checkOutput("sb_ovf_b", longint'(ovf_b), longint'(e.o));
                end
            end
            if (in_valid && in_ready_a) begin
                model_acc = wrapAcc(model_acc + longint'(din0) * longint'(din1));
                if (in_last) begin
                    qa.push_back(requant(model_acc, 1'b1, 1'b1));
                    qb.push_back(requant(model_acc, 1'b0, 1'b0));
                    model_acc = 0;
                end
            end
        end
    end

    // Present one term and hold it until accepted; returns just after the accepting edge.
    task automatic sendTerm(input int d0, input int d1, input bit last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        din0     = 16'(d0);
        din1     = 8'(d1);
        in_last  = last;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            ok = in_ready_a;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("term_accepted", longint'(ok), 1);
    endtask

    // Wait (bounded) for one result from each instance and check value, flag and latency.
    task automatic waitResult(input string tag, input int ea, input bit oa,
                              input int eb, input bit ob, input bit chk_lat);
        bit     got_a;
        bit     got_b;
        int     lat_a;
        int     lat_b;
        longint da;
        longint db;
        bit     va;
        bit     vb;
        got_a = 0; got_b = 0; lat_a = -1; lat_b = -1;
        da = 0; db = 0; va = 0; vb = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!got_a && out_valid_a) begin
                got_a = 1; lat_a = k - 1; da = longint'(dout_a); va = ovf_a;
            end
            if (!got_b && out_valid_b) begin
                got_b = 1; lat_b = k - 1; db = longint'(dout_b); vb = ovf_b;
            end
            if (got_a && got_b) break;
        end
        checkOutput({tag, "_got_a"}, longint'(got_a), 1);
        checkOutput({tag, "_got_b"}, longint'(got_b), 1);
        checkOutput({tag, "_dout_a"}, da, longint'(ea));
        checkOutput({tag, "_ovf_a"}, longint'(va), longint'(oa));
        checkOutput({tag, "_dout_b"}, db, longint'(eb));
        checkOutput({tag, "_ovf_b"}, longint'(vb), longint'(ob));
        if (chk_lat) begin
            checkOutput({tag, "_lat_a"}, longint'(lat_a), 3);
            checkOutput({tag, "_lat_b"}, longint'(lat_b), 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        sendTerm(v.d0, v.d1, 1'b1);
        waitResult($sformatf("vec%0d", idx), v.exp_a, v.ovf_a, v.exp_b, v.ovf_b, 1'b1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   seen_a[$];
        int   cyc_a[$];
        int   seen_b[$];
        int   cyc_b[$];
        int   tmp;
        bit   got;

        // Single-term vectors: activation, weight, then expected (a) and (b) results.
        vecs.push_back('{100, 3, 5, 0, 4, 0});
        vecs.push_back('{-100, 3, -5, 0, -5, 0});
        vecs.push_back('{-32768, -128, 32767, 1, 0, 1});
        vecs.push_back('{64, 64, 64, 0, 64, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0});
        vecs.push_back('{32767, 127, 32767, 1, -514, 1});
        vecs.push_back('{-1, 1, 0, 0, -1, 0});
        vecs.push_back('{32, 1, 1, 0, 0, 0});
        vecs.push_back('{31, 1, 0, 0, 0, 0});
        vecs.push_back('{32767, 64, 32767, 0, 32767, 0});
        vecs.push_back('{-32768, 64, -32768, 0, -32768, 0});
        vecs.push_back('{-32768, -127, 32767, 1, -512, 1});
        vecs.push_back('{32767, -128, -32768, 1, 2, 1});

        ap_rst_n  = 1'b0;
        ce        = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        din0      = '0;
        din1      = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid_a", longint'(out_valid_a), 0);
        checkOutput("rst_dout_a", longint'(dout_a), 0);
        checkOutput("rst_ovf_a", longint'(ovf_a), 0);
        checkOutput("rst_out_valid_b", longint'(out_valid_b), 0);
        checkOutput("rst_in_ready_b", longint'(in_ready_b), 1);
        @(posedge clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single-term vectors");
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        $display("[TB] back-to-back dot products");
        sendTerm(10, 64, 0);
        sendTerm(20, 64, 0);
        sendTerm(-5, 64, 0);
        sendTerm(7, 64, 1);
        sendTerm(64, 64, 1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid_a) begin seen_a.push_back(int'(dout_a)); cyc_a.push_back(k); end
            if (out_valid_b) begin seen_b.push_back(int'(dout_b)); cyc_b.push_back(k); end
        end
        @(posedge clk);
        #1;
        checkOutput("b2b_count_a", seen_a.size(), 2);
        checkOutput("b2b_count_b", seen_b.size(), 2);
        if (seen_a.size() == 2) begin
            checkOutput("b2b_first_a", seen_a[0], 32);
            checkOutput("b2b_second_a", seen_a[1], 64);
            checkOutput("b2b_gap_a", cyc_a[1] - cyc_a[0], 1);
        end
        if (seen_b.size() == 2) begin
            checkOutput("b2b_first_b", seen_b[0], 32);
            checkOutput("b2b_second_b", seen_b[1], 64);
            checkOutput("b2b_gap_b", cyc_b[1] - cyc_b[0], 1);
        end

        $display("[TB] output backpressure");
        out_ready = 1'b0;
        sendTerm(64, 1, 1);
        sendTerm(64, 2, 1);
        sendTerm(64, 3, 1);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid_a) begin got = 1; break; end
        end
        checkOutput("bp_first_valid", longint'(got), 1);
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_in_ready", longint'(in_ready_a), 0);
            checkOutput("bp_out_valid", longint'(out_valid_a), 1);
            checkOutput("bp_dout_held", longint'(dout_a), 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        seen_a.delete();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid_a) seen_a.push_back(int'(dout_a));
        end
        @(posedge clk);
        #1;
        checkOutput("bp_delivered", seen_a.size(), 3);
        for (int i = 0; i < seen_a.size() && i < 3; i++) begin
            checkOutput($sformatf("bp_order%0d", i), seen_a[i], i + 1);
        end

        $display("[TB] reset mid-stream");
        sendTerm(10, 64, 0);
        sendTerm(20, 64, 0);
        repeat (4) begin @(posedge clk); #1; end
        sendTerm(30, 64, 0);
        ap_rst_n = 1'b0;
        @(posedge clk);
        #1;
        ap_rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_out_valid", longint'(out_valid_a), 0);
        checkOutput("mid_rst_dout", longint'(dout_a), 0);
        checkOutput("mid_rst_ovf", longint'(ovf_a), 0);
        @(posedge clk);
        #1;
        sendTerm(64, 64, 1);
        waitResult("post_rst", 64, 0, 64, 0, 1'b1);

        $display("[TB] clock-enable stall mid-stream");
        sendTerm(10, 64, 0);
        sendTerm(20, 64, 0);
        ce       = 1'b0;
        in_valid = 1'b1;
        din0     = -16'sd5;
        din1     = 8'sd64;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("ce_in_ready", longint'(in_ready_a), 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        ce       = 1'b1;
        sendTerm(-5, 64, 0);
        sendTerm(7, 64, 1);
        waitResult("ce_stream", 32, 0, 32, 0, 1'b1);

        sendTerm(64, 64, 1);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid_a) begin got = 1; break; end
        end
        checkOutput("ce_hold_seen", longint'(got), 1);
        ce = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("ce_hold_valid", longint'(out_valid_a), 1);
            checkOutput("ce_hold_dout", longint'(dout_a), 64);
            checkOutput("ce_hold_in_ready", longint'(in_ready_a), 0);
        end
        @(posedge clk);
        #1;
        ce = 1'b1;
        @(negedge clk);
        checkOutput("ce_release_valid", longint'(out_valid_a), 1);
        @(negedge clk);
        checkOutput("ce_consumed", longint'(out_valid_a), 0);
        @(posedge clk);
        #1;

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 99) < 65);
            if ($urandom_range(0, 1) == 1) begin
                din0 = 16'($urandom);
                din1 = 8'($urandom);
            end else begin
                tmp  = int'($urandom_range(0, 600)) - 300;
                din0 = 16'(tmp);
                tmp  = int'($urandom_range(0, 40)) - 20;
                din1 = 8'(tmp);
            end
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 99) < 70);
            ce        = ($urandom_range(0, 99) < 90);
            ap_rst_n  = !($urandom_range(0, 499) == 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        ce        = 1'b1;
        out_ready = 1'b1;
        ap_rst_n  = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        checkOutput("drain_qa_empty", qa.size(), 0);
        checkOutput("drain_qb_empty", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
